// File: rtl/shifter16.sv
// 16-bit logarithmic barrel shifter (SLL / SRA / ROR) with a combinational
// result and a registered copy for pipelined consumers.
module shifter16 #(
    parameter int WIDTH = 16,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Shift_In,
    input  logic [SW-1:0]    Shift_Val,
    input  logic [1:0]       Mode,
    output logic [WIDTH-1:0] Shift_Out,
    output logic [WIDTH-1:0] Shift_Out_q
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    // stage_data[k] is the operand after the first k stages (1, 2, 4, 8 ...).
    logic [WIDTH-1:0] stage_data [SW+1];
    logic [WIDTH-1:0] shift_out_q_reg;

    assign stage_data[0] = Shift_In;

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_stage
            localparam int AMT = 2 ** gi;
            logic [WIDTH-1:0] sll_val;
            logic [WIDTH-1:0] sra_val;
            logic [WIDTH-1:0] ror_val;

            // The MSB survives every SRA stage, so each stage can sign-fill
            // from its own input rather than from the original operand.
            assign sll_val = {stage_data[gi][WIDTH-1-AMT:0], {AMT{1'b0}}};
            assign sra_val = {{AMT{stage_data[gi][WIDTH-1]}}, stage_data[gi][WIDTH-1:AMT]};
            assign ror_val = {stage_data[gi][AMT-1:0], stage_data[gi][WIDTH-1:AMT]};

            assign stage_data[gi+1] = !Shift_Val[gi]     ? stage_data[gi] :
                                      (Mode == MODE_SLL) ? sll_val :
                                      (Mode == MODE_SRA) ? sra_val :
                                      (Mode == MODE_ROR) ? ror_val :
                                                           stage_data[gi];
        end
    endgenerate

    assign Shift_Out = stage_data[SW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_out_q_reg <= '0;
        end else begin
            shift_out_q_reg <= Shift_Out;
        end
    end

    assign Shift_Out_q = shift_out_q_reg;

endmodule

// File: tb/tb_shifter16.sv
// Self-checking bench for shifter16: directed cases, randomized vectors
// against an arithmetic reference, and register/reset behaviour.
module tb_shifter16;

    logic        clk;
    logic        rst_n;
    logic [15:0] shift_in;
    logic [3:0]  shift_val;
    logic [1:0]  mode;
    logic [15:0] shift_out;
    logic [15:0] shift_out_q;

    int n_checks = 0;
    int n_fail   = 0;

    shifter16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Shift_In    (shift_in),
        .Shift_Val   (shift_val),
        .Mode        (mode),
        .Shift_Out   (shift_out),
        .Shift_Out_q (shift_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_model(input logic [1:0] m, input logic [15:0] x,
                                              input logic [3:0] n);
        logic [31:0] dbl;
        logic signed [15:0] sx;
        case (m)
            2'b00: ref_model = x << n;
            2'b01: begin
                sx = x;
                ref_model = sx >>> n;
            end
            2'b10: begin
                dbl = {x, x} >> n;
                ref_model = dbl[15:0];
            end
            default: ref_model = x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic [1:0] m, input logic [15:0] x, input logic [3:0] n);
        mode      = m;
        shift_in  = x;
        shift_val = n;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  m;
        logic [15:0] x;
        logic [3:0]  n;
        logic [15:0] expv;

        rst_n = 1'b0;
        apply(2'b00, 16'h0000, 4'd0);
        #1;
        check("reset_q", shift_out_q, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed combinational cases, no clock advance
        apply(2'b00, 16'h8421, 4'd4);  check("sll_4",   shift_out, 16'h4210);
        apply(2'b00, 16'h8421, 4'd0);  check("sll_0",   shift_out, 16'h8421);
        apply(2'b00, 16'h8421, 4'd15); check("sll_15",  shift_out, 16'h8000);
        apply(2'b01, 16'hF000, 4'd4);  check("sra_neg", shift_out, 16'hFF00);
        apply(2'b01, 16'h7000, 4'd4);  check("sra_pos", shift_out, 16'h0700);
        apply(2'b01, 16'h8000, 4'd15); check("sra_15",  shift_out, 16'hFFFF);
        apply(2'b10, 16'h1234, 4'd4);  check("ror_4",   shift_out, 16'h4123);
        apply(2'b10, 16'h1234, 4'd15); check("ror_15",  shift_out, 16'h2468);
        apply(2'b10, 16'h1234, 4'd0);  check("ror_0",   shift_out, 16'h1234);
        apply(2'b11, 16'hBEEF, 4'd7);  check("rsvd",    shift_out, 16'hBEEF);

        // Randomized: combinational result, then the registered copy
        for (int i = 0; i < 84; i++) begin
            @(negedge clk);
            m    = (i < 24) ? 2'b00 : (i < 48) ? 2'b01 : (i < 72) ? 2'b10 : 2'b11;
            x    = 16'($urandom);
            n    = 4'($urandom_range(0, 15));
            expv = ref_model(m, x, n);
            apply(m, x, n);
            $display("rand %0d mode=%b in=%h val=%0d exp=%h got=%h", i, m, x, n, expv, shift_out);
            check("rand_comb", shift_out, expv);
            @(posedge clk);
            #1;
            check("rand_q", shift_out_q, expv);
        end

        // Asynchronous reset mid-cycle, held across an edge
        @(negedge clk);
        apply(2'b00, 16'h1234, 4'd1);
        @(posedge clk);
        #1;
        check("pre_rst_q", shift_out_q, 16'h2468);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", shift_out_q, 16'h0000);
        @(posedge clk);
        #1;
        check("held_rst_q", shift_out_q, 16'h0000);
        check("comb_in_rst", shift_out, 16'h2468);

        // Release between edges; first capture at the next rising clk
        @(negedge clk);
        rst_n = 1'b1;
        apply(2'b00, 16'h0001, 4'd3);
        check("rel_comb", shift_out, 16'h0008);
        check("rel_before_q", shift_out_q, 16'h0000);
        @(posedge clk);
        #1;
        check("rel_after_q", shift_out_q, 16'h0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shifter16.md
Name: shifter16

Overview:
- 16-bit barrel shifter for the processor ALU datapath.
- Supports three operations, selected by Mode, with a shift amount of 0..15:
  - logical shift left (SLL)
  - arithmetic shift right (SRA)
  - rotate right (ROR)
- The result is available combinationally on Shift_Out in the same cycle.
- A registered copy, Shift_Out_q, is provided for pipelined consumers.

Parameters:
- WIDTH, 16, data width. Fixed at 16; Shift_Val width is log2(WIDTH) = 4.

Ports:
- clk        input   1   system clock, rising-edge active
- rst_n      input   1   reset, asynchronous, active-low
- Shift_In   input   16  operand to be shifted
- Shift_Val  input   4   shift/rotate amount, unsigned 0..15
- Mode       input   2   operation select: 00=SLL, 01=SRA, 10=ROR, 11=reserved
- Shift_Out  output  16  combinational result
- Shift_Out_q output 16  Shift_Out registered on rising clk

Behaviour:
- Shift_Out is purely combinational from Shift_In, Shift_Val and Mode.
  - Zero latency; valid within the same evaluation, with no clock dependence.
  - Unaffected by rst_n.
- Mode 00 (SLL): Shift_Out = (Shift_In << Shift_Val) truncated to 16 bits; vacated LSBs are 0.
- Mode 01 (SRA): Shift_Out = signed Shift_In >>> Shift_Val.
  - Vacated MSBs are filled with Shift_In[15].
- Mode 10 (ROR): Shift_Out = lower 16 bits of ({Shift_In, Shift_In} >> Shift_Val).
  - Equivalently, bit i of Shift_Out = Shift_In[(i + Shift_Val) mod 16].
- Mode 11: reserved. Shift_Out = Shift_In (pass-through, no shift).
- Shift_Val = 0: Shift_Out = Shift_In for every mode.
- Shift_Val = 15:
  - SLL gives {Shift_In[0], 15'b0}.
  - SRA gives 16 copies of Shift_In[15].
  - ROR gives {Shift_In[14:0], Shift_In[15]}.
- Implementation: log-shifter with four cascaded stages (1, 2, 4, 8), each stage controlled by one bit of Shift_Val.
  - Each stage is a per-mode mux: zero fill for SLL, sign fill for SRA, wrap fill for ROR.
  - No multipliers; no `<<`/`>>>` by a variable amount required.
- Shift_Out_q:
  - rst_n low: asynchronously clears Shift_Out_q to 16'h0000, and it holds 0 while rst_n is low.
  - rst_n high: on each rising clk, Shift_Out_q <= Shift_Out, giving 1-cycle latency.
  - rst_n deasserting between edges: the first capture occurs at the next rising clk.
  - Reset asserted mid-operation discards the pending result; there is no other state.
- No handshake; inputs may change every cycle.

Test Plan:
- SLL: Mode=00, Shift_In=16'h8421, Shift_Val=4 -> Shift_Out=16'h4210.
  - Also Shift_Val=0 -> 16'h8421.
  - Also Shift_Val=15 -> 16'h8000.
- SRA:
  - Mode=01, Shift_In=16'hF000, Shift_Val=4 -> 16'hFF00.
  - Shift_In=16'h7000, Shift_Val=4 -> 16'h0700.
  - Shift_In=16'h8000, Shift_Val=15 -> 16'hFFFF.
- ROR:
  - Mode=10, Shift_In=16'h1234, Shift_Val=4 -> 16'h4123.
  - Shift_Val=15 -> 16'h2468.
  - Shift_Val=0 -> 16'h1234.
- Reserved: Mode=11, Shift_In=16'hBEEF, Shift_Val=7 -> Shift_Out=16'hBEEF.
- Randomized: 21+ random {Shift_In, Shift_Val} per mode 00/01/10, compared against golden models:
  - `<<` for SLL
  - `>>>` on signed for SRA
  - `({x,x}>>n)[15:0]` for ROR
  - Checked with no clock advance, i.e. combinational.
- Register/reset:
  - Assert rst_n=0 asynchronously mid-cycle -> Shift_Out_q=0 immediately.
  - Release, apply Mode=00, Shift_In=16'h0001, Shift_Val=3 -> Shift_Out_q=16'h0008 after the next rising clk, still 0 before it.
